// File: rtl/rect_engine.sv
// Rectangle fill / invert / copy engine on framebuffer port B.
// Accepts one command from the register block, then walks the clipped rectangle one pixel at a time.
module rect_engine #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 200,
    parameter int XW     = 9,
    parameter int YW     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [XW-1:0] x0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y0,
    input  logic [YW-1:0] y1,
    input  logic [XW-1:0] sx,
    input  logic [YW-1:0] sy,
    input  logic          colour,
    output logic          busy,
    output logic          done,
    output logic [XW-1:0] x_b,
    output logic [YW-1:0] y_b,
    output logic          read_b,
    output logic          write_b,
    output logic          in_b,
    input  logic          out_b,
    input  logic          rdy_b,
    output logic [2:0]    state_dbg
);

    // Command handshake: a command transfers on the rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE and the fields are latched on that same edge.

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_RD_REQ  = 3'd2,
        S_RD_WAIT = 3'd3,
        S_WR_REQ  = 3'd4,
        S_WR_WAIT = 3'd5,
        S_NEXT    = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    localparam logic [1:0]    OP_FILL = 2'd0;
    localparam logic [1:0]    OP_INV  = 2'd1;
    localparam logic [1:0]    OP_COPY = 2'd2;
    localparam logic [1:0]    OP_NONE = 2'd3;
    localparam logic [XW:0]   X_LIM   = (XW+1)'(WIDTH);
    localparam logic [YW:0]   Y_LIM   = (YW+1)'(HEIGHT);
    localparam logic [XW-1:0] X_LAST  = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(HEIGHT - 1);

    state_t        state;
    logic [1:0]    op_q;
    logic [XW-1:0] x0_q, x1_q, sx_q, cur_x;
    logic [YW-1:0] y0_q, y1_q, sy_q, cur_y;
    logic          colour_q;

    logic [XW-1:0] raw_xmax, xmin, xmax;
    logic [YW-1:0] raw_ymax, ymin, ymax;
    logic          empty, backward;

    // Normalised, clipped rectangle derived from the latched fields; stable for the whole command.
    always_comb begin
        xmin     = (x0_q < x1_q) ? x0_q : x1_q;
        raw_xmax = (x0_q < x1_q) ? x1_q : x0_q;
        ymin     = (y0_q < y1_q) ? y0_q : y1_q;
        raw_ymax = (y0_q < y1_q) ? y1_q : y0_q;
        xmax     = ({1'b0, raw_xmax} >= X_LIM) ? X_LAST : raw_xmax;
        ymax     = ({1'b0, raw_ymax} >= Y_LIM) ? Y_LAST : raw_ymax;
        empty    = ({1'b0, xmin} >= X_LIM) || ({1'b0, ymin} >= Y_LIM);
        backward = (op_q == OP_COPY) && !((sy_q > ymin) || ((sy_q == ymin) && (sx_q >= xmin)));
    end

    logic [XW-1:0] step_x, launch_x, launch_xb;
    logic [YW-1:0] step_y, launch_y, launch_yb;
    logic [XW:0]   src_x;
    logic [YW:0]   src_y;
    logic          last, src_oob, launch_in;
    state_t        launch_st;

    // Pixel iterator and the first access for the pixel about to be started.
    always_comb begin
        step_x = cur_x;
        step_y = cur_y;
        last   = 1'b0;
        if (!backward) begin
            if (cur_x == xmax) begin
                step_x = xmin;
                step_y = cur_y + 1'b1;
                last   = (cur_y == ymax);
            end else begin
                step_x = cur_x + 1'b1;
            end
        end else begin
            if (cur_x == xmin) begin
                step_x = xmax;
                step_y = cur_y - 1'b1;
                last   = (cur_y == ymin);
            end else begin
                step_x = cur_x - 1'b1;
            end
        end

        if (state == S_SETUP) begin
            launch_x = backward ? xmax : xmin;
            launch_y = backward ? ymax : ymin;
        end else begin
            launch_x = step_x;
            launch_y = step_y;
        end

        // One extra bit so a source run past the edge is seen as out of range rather than wrapping.
        src_x   = {1'b0, sx_q} + {1'b0, launch_x} - {1'b0, xmin};
        src_y   = {1'b0, sy_q} + {1'b0, launch_y} - {1'b0, ymin};
        src_oob = (src_x >= X_LIM) || (src_y >= Y_LIM);

        launch_st = S_DONE;
        launch_xb = launch_x;
        launch_yb = launch_y;
        launch_in = 1'b0;
        case (op_q)
            OP_FILL: begin
                launch_st = S_WR_REQ;
                launch_in = colour_q;
            end
            OP_INV: begin
                launch_st = S_RD_REQ;
            end
            OP_COPY: begin
                if (src_oob) begin
                    launch_st = S_WR_REQ;
                end else begin
                    launch_st = S_RD_REQ;
                    launch_xb = src_x[XW-1:0];
                    launch_yb = src_y[YW-1:0];
                end
            end
            default: launch_st = S_DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            op_q     <= '0;
            x0_q     <= '0;
            x1_q     <= '0;
            y0_q     <= '0;
            y1_q     <= '0;
            sx_q     <= '0;
            sy_q     <= '0;
            colour_q <= 1'b0;
            cur_x    <= '0;
            cur_y    <= '0;
            x_b      <= '0;
            y_b      <= '0;
            in_b     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q     <= cmd_op;
                        x0_q     <= x0;
                        x1_q     <= x1;
                        y0_q     <= y0;
                        y1_q     <= y1;
                        sx_q     <= sx;
                        sy_q     <= sy;
                        colour_q <= colour;
                        state    <= S_SETUP;
                    end
                end
                S_SETUP, S_NEXT: begin
                    if (empty || (op_q == OP_NONE) || ((state == S_NEXT) && last)) begin
                        state <= S_DONE;
                    end else begin
                        cur_x <= launch_x;
                        cur_y <= launch_y;
                        x_b   <= launch_xb;
                        y_b   <= launch_yb;
                        in_b  <= launch_in;
                        state <= launch_st;
                    end
                end
                // A completion pulse coinciding with the request cycle is not for this request.
                S_RD_REQ: state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    if (rdy_b) begin
                        x_b   <= cur_x;
                        y_b   <= cur_y;
                        in_b  <= (op_q == OP_INV) ? ~out_b : out_b;
                        state <= S_WR_REQ;
                    end
                end
                S_WR_REQ: state <= S_WR_WAIT;
                S_WR_WAIT: begin
                    if (rdy_b) begin
                        state <= S_NEXT;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Pure decodes of the state flop, so they change only on clock edges.
    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done      = (state == S_DONE);
    assign read_b    = (state == S_RD_REQ);
    assign write_b   = (state == S_WR_REQ);
    assign state_dbg = state;

endmodule

// File: tb/tb_rect_engine.sv
// Directed bench for rect_engine: a port-B RAM model with adjustable latency logs every write,
// and each command's writes are checked against a hand-computed expected queue.
module tb_rect_engine;

    localparam int WIDTH  = 320;
    localparam int HEIGHT = 200;
    localparam int XW     = 9;
    localparam int YW     = 8;
    localparam int PW     = XW + YW + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [XW-1:0] x0, x1, sx;
    logic [YW-1:0] y0, y1, sy;
    logic          colour;
    logic          busy, done;
    logic [XW-1:0] x_b;
    logic [YW-1:0] y_b;
    logic          read_b, write_b, in_b;
    logic          out_b;
    logic          rdy_b;
    logic [2:0]    state_dbg;

    rect_engine #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .XW(XW), .YW(YW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1), .sx(sx), .sy(sy), .colour(colour),
        .busy(busy), .done(done),
        .x_b(x_b), .y_b(y_b), .read_b(read_b), .write_b(write_b), .in_b(in_b),
        .out_b(out_b), .rdy_b(rdy_b), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- RAM model on port B ----------------
    logic [WIDTH-1:0] mem [HEIGHT];
    logic [PW-1:0]    wr_log[$];
    logic [PW-1:0]    exp_q[$];
    int               lat = 1;
    logic             pend = 1'b0;
    logic             pend_rd, pend_d;
    logic [XW-1:0]    pend_x;
    logic [YW-1:0]    pend_y;
    int               pend_cnt;
    int               rd_pulses = 0, wr_pulses = 0, done_cnt = 0, proto_err = 0;

    task automatic respond(input logic rd, input logic [XW-1:0] ax, input logic [YW-1:0] ay, input logic d);
        rdy_b <= 1'b1;
        if (rd) begin
            out_b <= mem[ay][ax];
        end else begin
            mem[ay][ax] = d;
            wr_log.push_back({ax, ay, d});
        end
    endtask

    always @(posedge clk) begin
        rdy_b <= 1'b0;
        if (!rst) begin
            pend <= 1'b0;
        end else begin
            if (read_b)  rd_pulses++;
            if (write_b) wr_pulses++;
            if (done)    done_cnt++;
            if (read_b && write_b) proto_err++;
            if (pend && (read_b || write_b)) proto_err++;
            if (pend) begin
                if (pend_cnt <= 1) begin
                    respond(pend_rd, pend_x, pend_y, pend_d);
                    pend <= 1'b0;
                end else begin
                    pend_cnt <= pend_cnt - 1;
                end
            end else if (read_b || write_b) begin
                if (lat <= 1) begin
                    respond(read_b, x_b, y_b, in_b);
                end else begin
                    pend     <= 1'b1;
                    pend_cnt <= lat - 1;
                    pend_rd  <= read_b;
                    pend_x   <= x_b;
                    pend_y   <= y_b;
                    pend_d   <= in_b;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [XW-1:0] ax, input logic [YW-1:0] ay, input logic d);
        exp_q.push_back({ax, ay, d});
    endtask

    task automatic check_writes(input string tag);
        logic [PW-1:0] e, o;
        check({tag, "_nwrites"}, wr_log.size(), exp_q.size());
        while (exp_q.size() > 0 && wr_log.size() > 0) begin
            e = exp_q.pop_front();
            o = wr_log.pop_front();
            check({tag, "_write"}, 32'(o), 32'(e));
        end
        exp_q.delete();
        wr_log.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic [1:0] op, input logic [XW-1:0] ax0, input logic [XW-1:0] ax1,
                            input logic [YW-1:0] ay0, input logic [YW-1:0] ay1,
                            input logic [XW-1:0] asx, input logic [YW-1:0] asy, input logic col);
        @(negedge clk);
        cmd_op = op; x0 = ax0; x1 = ax1; y0 = ay0; y1 = ay1; sx = asx; sy = asy; colour = col;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        // Fields must have been latched; scribble over them while the engine runs.
        cmd_op = 2'($urandom_range(0, 3));
        x0 = XW'($urandom_range(0, 511)); x1 = XW'($urandom_range(0, 511));
        y0 = YW'($urandom_range(0, 255)); y1 = YW'($urandom_range(0, 255));
        sx = XW'($urandom_range(0, 511)); sy = YW'($urandom_range(0, 255));
        colour = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1 && !done) check({tag, "_busy_after_accept"}, busy, 1);
        end while (!done && n < 3000);
        check({tag, "_done_seen"}, done, 1);
        check({tag, "_busy_at_done"}, busy, 0);
    endtask

    task automatic post_done(input string tag, input int d0);
        @(negedge clk);
        check({tag, "_done_pulse_len"}, done, 0);
        check({tag, "_ready_after"}, cmd_ready, 1);
        check({tag, "_done_count"}, done_cnt, d0 + 1);
    endtask

    // ---------------- directed sequence ----------------
    int cyc, d0, r0, w0, addr_bad;

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; x0 = '0; x1 = '0; y0 = '0; y1 = '0;
        sx = '0; sy = '0; colour = 1'b0; out_b = 1'b0; rdy_b = 1'b0;
        for (int i = 0; i < HEIGHT; i++) mem[i] = '0;
        repeat (3) @(negedge clk);

        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_read", read_b, 0);
        check("rst_write", write_b, 0);
        check("rst_in_b", in_b, 0);
        check("rst_xy", {x_b, y_b}, 0);
        check("rst_state", state_dbg, 0);
        rst = 1'b1;
        @(negedge clk);

        // Single-row fill, 3 cycles per pixel
        d0 = done_cnt;
        push_exp(2, 3, 1); push_exp(3, 3, 1); push_exp(4, 3, 1);
        send_cmd(2'd0, 2, 4, 3, 3, 0, 0, 1'b1);
        wait_done("fill_row", cyc);
        check("fill_row_cycles", cyc, 11);
        post_done("fill_row", d0);
        check_writes("fill_row");

        // Swapped corners, colour 0
        d0 = done_cnt;
        push_exp(8, 4, 0); push_exp(9, 4, 0); push_exp(10, 4, 0);
        push_exp(8, 5, 0); push_exp(9, 5, 0); push_exp(10, 5, 0);
        send_cmd(2'd0, 10, 8, 5, 4, 0, 0, 1'b0);
        wait_done("fill_swap", cyc);
        check("fill_swap_cycles", cyc, 20);
        post_done("fill_swap", d0);
        check_writes("fill_swap");

        // Right-edge clip
        d0 = done_cnt;
        push_exp(318, 199, 1); push_exp(319, 199, 1);
        send_cmd(2'd0, 318, 400, 199, 199, 0, 0, 1'b1);
        wait_done("fill_clip", cyc);
        check("fill_clip_cycles", cyc, 8);
        post_done("fill_clip", d0);
        check_writes("fill_clip");

        // Fully clipped in x, then in y
        d0 = done_cnt; w0 = wr_pulses;
        send_cmd(2'd0, 320, 330, 0, 0, 0, 0, 1'b1);
        wait_done("empty_x", cyc);
        check("empty_x_cycles", cyc, 2);
        post_done("empty_x", d0);
        check("empty_x_no_writes", wr_pulses, w0);
        check_writes("empty_x");

        d0 = done_cnt; w0 = wr_pulses;
        send_cmd(2'd0, 0, 5, 200, 210, 0, 0, 1'b1);
        wait_done("empty_y", cyc);
        check("empty_y_cycles", cyc, 2);
        post_done("empty_y", d0);
        check("empty_y_no_writes", wr_pulses, w0);

        // Reserved op: accepted, no accesses
        d0 = done_cnt; w0 = wr_pulses; r0 = rd_pulses;
        send_cmd(2'd3, 0, 3, 0, 3, 0, 0, 1'b1);
        wait_done("op3", cyc);
        check("op3_cycles", cyc, 2);
        post_done("op3", d0);
        check("op3_no_access", (wr_pulses - w0) + (rd_pulses - r0), 0);

        // Overlapping copy one pixel right: must scan backward
        mem[0][0] = 1'b1; mem[0][1] = 1'b0; mem[0][2] = 1'b0;
        d0 = done_cnt; r0 = rd_pulses;
        push_exp(2, 0, 0); push_exp(1, 0, 1);
        send_cmd(2'd2, 1, 2, 0, 0, 0, 0, 1'b0);
        wait_done("copy_back", cyc);
        check("copy_back_cycles", cyc, 12);
        post_done("copy_back", d0);
        check("copy_back_reads", rd_pulses - r0, 2);
        check("copy_back_ram", {mem[0][0], mem[0][1], mem[0][2]}, 3'b110);
        check_writes("copy_back");

        // Forward copy whose source runs off the right edge
        mem[10][319] = 1'b1;
        d0 = done_cnt; r0 = rd_pulses;
        push_exp(5, 10, 1); push_exp(6, 10, 0);
        send_cmd(2'd2, 5, 6, 10, 10, 319, 10, 1'b0);
        wait_done("copy_oob", cyc);
        check("copy_oob_cycles", cyc, 10);
        post_done("copy_oob", d0);
        check("copy_oob_reads", rd_pulses - r0, 1);
        check_writes("copy_oob");

        // Invert with a slow RAM: single read pulse, address held throughout
        lat = 7;
        d0 = done_cnt; r0 = rd_pulses; addr_bad = 0; cyc = 0;
        push_exp(7, 7, 1);
        send_cmd(2'd1, 7, 7, 7, 7, 0, 0, 1'b0);
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (!done && cyc >= 2 && (x_b !== 9'd7 || y_b !== 8'd7)) addr_bad++;
        end
        check("inv_slow_done_seen", done, 1);
        post_done("inv_slow", d0);
        check("inv_slow_reads", rd_pulses - r0, 1);
        check("inv_slow_addr_stable", addr_bad, 0);
        check("inv_slow_ram", mem[7][7], 1);
        check_writes("inv_slow");
        lat = 1;

        // Invert two pixels at full speed, 5 cycles per pixel
        mem[8][9] = 1'b1;
        d0 = done_cnt;
        push_exp(8, 8, 1); push_exp(9, 8, 0);
        send_cmd(2'd1, 8, 9, 8, 8, 0, 0, 1'b0);
        wait_done("inv_fast", cyc);
        check("inv_fast_cycles", cyc, 12);
        post_done("inv_fast", d0);
        check_writes("inv_fast");

        // Reset mid-fill, then a fresh command
        d0 = done_cnt;
        send_cmd(2'd0, 0, 9, 0, 0, 0, 0, 1'b1);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_write", write_b, 0);
        check("midrst_read", read_b, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_ready", cmd_ready, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_no_done_pulse", done_cnt, d0);
        wr_log.delete();
        push_exp(0, 1, 1); push_exp(1, 1, 1);
        send_cmd(2'd0, 0, 1, 1, 1, 0, 0, 1'b1);
        wait_done("after_rst", cyc);
        check("after_rst_cycles", cyc, 8);
        post_done("after_rst", d0);
        check_writes("after_rst");

        check("protocol_errors", proto_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
